// File: rtl/restoring_divider.sv
// restoring_divider
//   Multi-cycle restoring divider producing one quotient bit per clock, with a
//   start/busy/ready handshake and divide-by-zero flagging. Used as the shared
//   integer-division unit for datapaths that can tolerate WIDTH cycles of latency.
//
//   Optional feature macro: SIGNED_DIV_EN
//     undefined : unsigned operands and results, busy lasts WIDTH cycles.
//     defined   : two's-complement operands and results; magnitudes are divided
//                 unsigned and an extra FIX state applies the signs, so busy
//                 lasts WIDTH+1 cycles.
//
//   Parameters
//     WIDTH  operand, quotient and remainder width (>= 2)
//
//   Ports
//     clk    in   rising-edge clock
//     rst    in   synchronous active-high reset
//     start  in   request, sampled only in IDLE or DONE
//     a      in   dividend, latched on an accepted start
//     b      in   divisor, latched on an accepted start
//     busy   out  division in progress
//     ready  out  q/r/dbz hold a valid result
//     q      out  quotient (registered)
//     r      out  remainder (registered)
//     dbz    out  last result was a divide-by-zero
//
//   state | meaning
//   IDLE  | after reset, no result held
//   RUN   | shifting/subtracting, one quotient bit per clock
//   FIX   | applies quotient/remainder signs (SIGNED_DIV_EN only)
//   DONE  | result valid on q/r/dbz, waiting for next start

module restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             ready,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             dbz
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

`ifdef SIGNED_DIV_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_FIX  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] a_q, a_d;         // raw dividend, returned as r on divide-by-zero
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH+1:0] trial;
   logic [WIDTH:0]   rem_nx;
   logic [WIDTH-1:0] dvd_nx;

`ifdef SIGNED_DIV_EN
   logic neg_q_q, neg_q_d;   // quotient must be negated
   logic neg_r_q, neg_r_d;   // remainder follows the dividend sign

   // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits unsigned in WIDTH bits
   always_comb begin
      a_mag = a[WIDTH-1] ? -a : a;
      b_mag = b[WIDTH-1] ? -b : b;
   end
`else
   always_comb begin
      a_mag = a;
      b_mag = b;
   end
`endif

   // One restoring step: rem_q < divisor always, so the shifted value never
   // overflows WIDTH+2 bits and the trial sign bit decides keep/restore.
   always_comb begin
      trial = {rem_q, dvd_q[WIDTH-1]} - {2'b00, dvs_q};
      if (trial[WIDTH+1]) begin
         rem_nx = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
         dvd_nx = {dvd_q[WIDTH-2:0], 1'b0};
      end else begin
         rem_nx = trial[WIDTH:0];
         dvd_nx = {dvd_q[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      a_d     = a_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = CNT_INIT;
               rem_d   = '0;
               dvd_d   = a_mag;
               dvs_d   = b_mag;
               a_d     = a;
`ifdef SIGNED_DIV_EN
               neg_q_d = a[WIDTH-1] ^ b[WIDTH-1];
               neg_r_d = a[WIDTH-1];
`endif
            end
         end
         S_RUN: begin
            if (dvs_q == '0) begin
               state_d = S_DONE;
               cnt_d   = '0;
               q_d     = '1;
               r_d     = a_q;
               dbz_d   = 1'b1;
            end else begin
               rem_d = rem_nx;
               dvd_d = dvd_nx;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
`ifdef SIGNED_DIV_EN
                  state_d = S_FIX;
`else
                  state_d = S_DONE;
                  q_d     = dvd_nx;
                  r_d     = rem_nx[WIDTH-1:0];
                  dbz_d   = 1'b0;
`endif
               end
            end
         end
`ifdef SIGNED_DIV_EN
         S_FIX: begin
            // Overflow case -2^(WIDTH-1)/-1 falls out naturally: the magnitude
            // quotient 2^(WIDTH-1) is unnegated and reads back as -2^(WIDTH-1).
            state_d = S_DONE;
            q_d     = neg_q_q ? -dvd_q : dvd_q;
            r_d     = neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            dbz_d   = 1'b0;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         a_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         a_q     <= a_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
`endif
      end
   end

`ifdef SIGNED_DIV_EN
   assign busy = (state_q == S_RUN) || (state_q == S_FIX);
`else
   assign busy = (state_q == S_RUN);
`endif
   assign ready = (state_q == S_DONE);
   assign q     = q_q;
   assign r     = r_q;
   assign dbz   = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

   localparam int W = 8;
`ifdef SIGNED_DIV_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, ready;
   logic [W-1:0] q, r;
   logic         dbz;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] prev_q;

   restoring_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .ready(ready), .q(q), .r(r), .dbz(dbz)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model from plain arithmetic.
   function automatic void ref_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   output logic [W-1:0] eq, output logic [W-1:0] er,
                                   output logic ed);
`ifdef SIGNED_DIV_EN
      int sa, sb;
      sa = $signed(av);
      sb = $signed(bv);
      if (bv == 0) begin
         eq = '1; er = av; ed = 1'b1;
      end else if (sa == -(1 << (W-1)) && sb == -1) begin
         eq = av; er = '0; ed = 1'b0;
      end else begin
         eq = W'(sa / sb); er = W'(sa % sb); ed = 1'b0;
      end
`else
      if (bv == 0) begin
         eq = '1; er = av; ed = 1'b1;
      end else begin
         eq = av / bv; er = av % bv; ed = 1'b0;
      end
`endif
   endfunction

   // Called just after an edge; leaves the bench just after the completing edge.
   task automatic run_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ed, input string nm);
      int n;
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      check({nm, "_busy_on_start"}, busy, 1'b1);
      check({nm, "_ready_drop"}, ready, 1'b0);
      check({nm, "_q_kept"}, q, prev_q);
      n = 0;
      while (busy && n < 40) begin
         check({nm, "_excl"}, busy & ready, 1'b0);
         n++;
         @(posedge clk); #1;
      end
      check({nm, "_busy_cycles"}, n, ed ? 1 : LAT);
      check({nm, "_ready"}, ready, 1'b1);
      check({nm, "_q"}, q, eq);
      check({nm, "_r"}, r, er);
      check({nm, "_dbz"}, dbz, ed);
      prev_q = eq;
   endtask

   initial begin
      vec_t tbl[8];
      logic [W-1:0] eq, er, av, bv;
      logic ed;
      int n;
      logic saw_ready;

`ifdef SIGNED_DIV_EN
      tbl[0] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0};
      tbl[1] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0};
      tbl[2] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};
      tbl[3] = '{8'h09, 8'h00, 8'hFF, 8'h09, 1'b1};
      tbl[4] = '{8'h09, 8'h02, 8'h04, 8'h01, 1'b0};
      tbl[5] = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0};
      tbl[6] = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0};
      tbl[7] = '{8'hF9, 8'hF9, 8'h01, 8'h00, 1'b0};
`else
      tbl[0] = '{8'h07, 8'h03, 8'h02, 8'h01, 1'b0};
      tbl[1] = '{8'h1E, 8'h05, 8'h06, 8'h00, 1'b0};
      tbl[2] = '{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0};
      tbl[3] = '{8'h09, 8'h00, 8'hFF, 8'h09, 1'b1};
      tbl[4] = '{8'h09, 8'h02, 8'h04, 8'h01, 1'b0};
      tbl[5] = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0};
      tbl[6] = '{8'h05, 8'hFF, 8'h00, 8'h05, 1'b0};
      tbl[7] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0};
`endif

      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_ready", ready, 1'b0);
      check("rst_q", q, '0);
      check("rst_r", r, '0);
      check("rst_dbz", dbz, 1'b0);
      rst = 1'b0;
      prev_q = '0;

      // Table vectors; entries after the first start from DONE (back-to-back)
      for (int i = 0; i < 8; i++)
         run_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, $sformatf("tbl%0d", i));

      // Result held while start stays low
      repeat (5) @(posedge clk);
      #1;
      check("hold_ready", ready, 1'b1);
      check("hold_q", q, tbl[7].q);
      check("hold_r", r, tbl[7].r);

      // Start pulse during busy is ignored
      a = 8'd100; b = 8'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      a = 8'd1; b = 8'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!ready && n < 40) begin n++; @(posedge clk); #1; end
      check("ign_ready", ready, 1'b1);
      check("ign_q", q, 8'd14);
      check("ign_r", r, 8'd2);
      prev_q = 8'd14;

      // Reset aborts an in-flight division
      a = 8'd200; b = 8'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_ready", ready, 1'b0);
      check("abort_q", q, '0);
      check("abort_r", r, '0);
      check("abort_dbz", dbz, 1'b0);
      saw_ready = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (ready || busy) saw_ready = 1'b1;
      end
      check("abort_no_result", saw_ready, 1'b0);
      prev_q = '0;

      // Random operands against the reference model
      for (int i = 0; i < 200; i++) begin
         av = W'($urandom);
         bv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         if ($urandom_range(0, 9) == 0) av = 8'h80;
         if ($urandom_range(0, 9) == 0) bv = 8'hFF;
         ref_div(av, bv, eq, er, ed);
         run_div(av, bv, eq, er, ed, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
